// File: rtl/exec_seq.sv
// Multi-cycle execute sequencer: issues MUL/long-MUL/FP ops to an external unit,
// stalls the PC while it runs, then writes one or two result words back.
module exec_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InstrValid,
  input  logic             IsMul,
  input  logic             IsLong,
  input  logic             IsFP,
  input  logic [3:0]       RdLo,
  input  logic [3:0]       RdHi,
  input  logic             Done,
  input  logic [WIDTH-1:0] ResLo,
  input  logic [WIDTH-1:0] ResHi,
  output logic             Start,
  output logic             Stall,
  output logic             Busy,
  output logic             RegWrite,
  output logic [3:0]       WA3,
  output logic [WIDTH-1:0] WD3,
  output logic             Error
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB_LO,
    S_WB_HI
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [3:0]       rdlo_q, rdlo_d;
  logic [3:0]       rdhi_q, rdhi_d;
  logic             long_q, long_d;
  logic             err_q, err_d;

  logic op;
  logic timeout_hit;

  assign op          = InstrValid & (IsMul | IsFP);
  assign timeout_hit = (cnt_q == TMO_LAST) & ~Done;
  assign Busy        = (state_q != S_IDLE);
  assign Error       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      rdlo_q  <= '0;
      rdhi_q  <= '0;
      long_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rdlo_q  <= rdlo_d;
      rdhi_q  <= rdhi_d;
      long_q  <= long_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    rdlo_d   = rdlo_q;
    rdhi_d   = rdhi_q;
    long_d   = long_q;
    err_d    = err_q;
    Start    = 1'b0;
    Stall    = 1'b0;
    RegWrite = 1'b0;
    WA3      = '0;
    WD3      = '0;

    unique case (state_q)
      S_IDLE: begin
        Stall = op;
        if (op) begin
          rdlo_d  = RdLo;
          rdhi_d  = RdHi;
          long_d  = IsMul & IsLong;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        Start   = 1'b1;
        Stall   = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The abort cycle releases the stall so the instruction retires at that edge.
        Stall = ~timeout_hit;
        if (Done) begin
          lo_d    = ResLo;
          hi_d    = ResHi;
          state_d = S_WB_LO;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB_LO: begin
        Stall    = long_q;
        RegWrite = (rdlo_q != 4'hF);
        WA3      = rdlo_q;
        WD3      = lo_q;
        state_d  = long_q ? S_WB_HI : S_IDLE;
      end
      S_WB_HI: begin
        RegWrite = (rdhi_q != 4'hF);
        WA3      = rdhi_q;
        WD3      = hi_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/exec_seq.md
# exec_seq

Multi-cycle execute sequencer for the single-cycle ARM core. It sits beside the instruction decoder and issues MUL, UMULL/SMULL and FP add/mul (16/32-bit) operations to an external multi-cycle unit through a start/done handshake. While the unit works, it stalls the PC. It then writes the result back through the single register-file write port: one word for MUL/FP, and two consecutive words (RdLo then RdHi) for long multiplies.

## Interface
Parameters:
- WIDTH, 32, data word width
- TIMEOUT, 15, maximum WAIT cycles without Done before abort; must be ≥ 1

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- InstrValid  in  1  current instruction is valid
- IsMul  in  1  decoder IsMul
- IsLong  in  1  UMULL/SMULL (two-word result); only meaningful with IsMul
- IsFP  in  1  FP instruction (FP_identifier match)
- RdLo  in  4  first destination register; the only destination for MUL/FP
- RdHi  in  4  second destination register; used only when IsLong
- Done  in  1  unit result valid, single-cycle pulse
- ResLo  in  WIDTH  result low word (MUL/FP result)
- ResHi  in  WIDTH  result high word
- Start  out  1  one-cycle issue pulse to the unit
- Stall  out  1  holds PC and instruction
- Busy  out  1  state ≠ IDLE
- RegWrite  out  1  register-file write enable (seq path)
- WA3  out  4  write address
- WD3  out  WIDTH  write data
- Error  out  1  sticky timeout flag

## Operation
- States: IDLE, ISSUE, WAIT, WB_LO, WB_HI.
- Trigger: op = InstrValid & (IsMul | IsFP).
- IDLE:
  - On op, latch RdLo, RdHi and long = IsMul & IsLong, then go to ISSUE.
  - Stall = op, combinationally.
- ISSUE:
  - Start = 1.
  - Clear timeout counter.
  - Go to WAIT unconditionally.
  - Done is ignored in this state.
- WAIT:
  - On Done, capture ResLo and ResHi into internal registers and go to WB_LO.
  - Otherwise increment the counter.
  - If the counter equals TIMEOUT-1 with no Done, set Error and go to IDLE. No writeback occurs.
  - If Done and the timeout coincide, Done wins.
- WB_LO:
  - RegWrite = 1, WA3 = latched RdLo, WD3 = captured lo.
  - Go to WB_HI if long, else IDLE.
- WB_HI:
  - RegWrite = 1, WA3 = latched RdHi, WD3 = captured hi.
  - Go to IDLE.
- Stall = (IDLE & op) | ISSUE | WAIT | (WB_LO & long). The final writeback cycle and the timeout cycle have Stall = 0, so the instruction retires at that edge.
- A write to R15 (latched address 4'hF) is suppressed: RegWrite = 0 that cycle, with the state sequence unchanged. Error is not set.
- If RdLo == RdHi on a long op, both writes occur and the hi word is the final value.
- Done received in IDLE, ISSUE, WB_LO or WB_HI is ignored.
- Error stays set until reset. Further ops still execute normally.
- Inputs IsMul, IsFP, IsLong, RdLo and RdHi are sampled only in IDLE.

## Timing
- Reset (synchronous):
  - State goes to IDLE; counter and captured data registers go to 0.
  - Error = 0.
  - Start = RegWrite = Busy = 0, WA3 = 0, WD3 = 0.
  - Stall follows the IDLE equation, so it is 0 when no op is present.
- Reset mid-operation abandons the op with no writeback. A later Done is ignored.
- Cycle numbering for an op detected in cycle 0:
  - Cycle 0: IDLE, Stall = 1.
  - Cycle 1: ISSUE, Start = 1.
  - Cycle 2 onward: WAIT.
- If Done arrives in cycle k ≥ 2:
  - WB_LO is in cycle k+1.
  - For a long op, WB_HI is in cycle k+2.
- Minimum occupancy: 4 cycles short, 5 cycles long.
- Timeout: WAIT spans cycles 2 to TIMEOUT+1. Error is registered in cycle TIMEOUT+2, and IDLE returns in that same cycle.
- Back-to-back ops: the next instruction is evaluated in IDLE the cycle after the final writeback. There are no idle bubbles beyond that.

## Test plan
- MUL, RdLo = 3, Done in cycle 3 with ResLo = 0x0000_002A:
  - Start in cycle 1.
  - Stall = 1 in cycles 0–3.
  - Cycle 4: RegWrite = 1, WA3 = 3, WD3 = 0x2A, Stall = 0.
  - Busy = 0 in cycle 5.
- UMULL, RdLo = 4, RdHi = 5, Done in cycle 2 with ResLo = 0xDEAD_BEEF, ResHi = 0x0000_0001:
  - Cycle 3: write R4 = 0xDEADBEEF, Stall = 1.
  - Cycle 4: write R5 = 1, Stall = 0.
- FP op with Done never asserted, TIMEOUT = 15:
  - No RegWrite at any point.
  - Error = 1 from cycle 17 and stays set.
  - A following MUL completes normally.
- Long op with RdHi = 15:
  - WB_LO writes normally.
  - WB_HI cycle has RegWrite = 0 and Stall = 0.
- Reset asserted in WAIT (cycle 3), Done pulsed in cycle 4:
  - From cycle 4: IDLE, all outputs 0.
  - No write occurs.
- Spurious Done while IDLE, and Done in the ISSUE cycle:
  - Both ignored.
  - The op still waits in WAIT for a later Done.
